// File: rtl/inperiph_pkg.sv
// Shared register map, STATUS/CTRL bit layout and small pack/decode helpers for the
// byte-stream input peripheral.
package inperiph_pkg;

    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;

    typedef enum logic [1:0] {
        RegData   = OFF_DATA[3:2],
        RegStatus = OFF_STATUS[3:2],
        RegCtrl   = OFF_CTRL[3:2],
        RegRsvd   = 2'd3
    } reg_sel_e;

    localparam int unsigned STAT_COUNT_LSB = 0;
    localparam int unsigned STAT_COUNT_W   = 9;
    localparam int unsigned STAT_EMPTY     = 9;
    localparam int unsigned STAT_FULL      = 10;
    localparam int unsigned STAT_UFL       = 11;
    localparam int unsigned STAT_TOTAL_LSB = 16;
    localparam int unsigned STAT_TOTAL_W   = 16;

    localparam int unsigned CTRL_POP     = 0;
    localparam int unsigned CTRL_FLUSH   = 1;
    localparam int unsigned CTRL_CLR_UFL = 2;

    typedef struct packed {
        logic clr_ufl;
        logic flush;
        logic pop;
    } ctrl_cmd_t;

    function automatic ctrl_cmd_t decode_ctrl(input logic [2:0] wbits);
        ctrl_cmd_t cmd;
        cmd.pop     = wbits[CTRL_POP];
        cmd.flush   = wbits[CTRL_FLUSH];
        cmd.clr_ufl = wbits[CTRL_CLR_UFL];
        return cmd;
    endfunction

    function automatic logic [31:0] pack_status(
        input logic [STAT_COUNT_W-1:0] count,
        input logic                    empty,
        input logic                    full,
        input logic                    ufl,
        input logic [STAT_TOTAL_W-1:0] total
    );
        logic [31:0] s;
        s = '0;
        s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        s[STAT_EMPTY]                     = empty;
        s[STAT_FULL]                      = full;
        s[STAT_UFL]                       = ufl;
        s[STAT_TOTAL_LSB +: STAT_TOTAL_W] = total;
        return s;
    endfunction

endpackage

// File: rtl/inperiph_fifo.sv
// Circular byte FIFO: storage, wrapping pointers and a separate occupancy counter.
// Flush overrides both push and pop on the same edge.
module inperiph_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [DW-1:0] head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop, wen;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    // A pop on an empty FIFO never moves the read pointer, even if a push lands this edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wen     = do_push && !flush_i && !reset;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/inperiph.sv
// Memory-mapped input peripheral: buffers an external byte stream in a FIFO that the
// CPU peeks, pops and flushes through a small register file.
module inperiph
    import inperiph_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   daddr,
    output logic [31:0]   drdata,
    input  logic [31:0]   dwdata,
    input  logic [3:0]    dwe,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    reg_sel_e    sel;
    ctrl_cmd_t   cmd;
    logic        ctrl_we;
    logic        pop_req, flush_req, clr_req;
    logic        push;
    logic [DW-1:0] head;
    logic [CW-1:0] count;
    logic        empty, full;
    logic        ufl_q, ufl_d;
    logic [15:0] total_q, total_d;
    logic        unused_bits;

    assign sel     = reg_sel_e'(daddr[3:2]);
    assign cmd     = decode_ctrl(dwdata[2:0]);
    assign ctrl_we = dwe[0] && (sel == RegCtrl);

    assign pop_req   = ctrl_we && cmd.pop;
    assign flush_req = ctrl_we && cmd.flush;
    assign clr_req   = ctrl_we && cmd.clr_ufl;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    assign unused_bits = ^{daddr[31:4], daddr[1:0], dwdata[31:3], dwe[3:1]};

    inperiph_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (in_data),
        .pop_i   (pop_req),
        .flush_i (flush_req),
        .head_o  (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    // Total counts every handshake, including a byte discarded by a concurrent flush.
    always_comb begin
        total_d = total_q + 16'(push);
        ufl_d   = ufl_q;
        if (clr_req) begin
            ufl_d = 1'b0;
        end
        if (pop_req && empty && !flush_req) begin
            ufl_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ufl_q   <= 1'b0;
            total_q <= '0;
        end else begin
            ufl_q   <= ufl_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        drdata = '0;
        unique case (sel)
            RegData:   drdata = 32'(head);
            RegStatus: drdata = pack_status(STAT_COUNT_W'(count), empty, full, ufl_q, total_q);
            RegCtrl:   drdata = '0;
            RegRsvd:   drdata = '0;
            default:   drdata = '0;
        endcase
    end

endmodule

// File: doc/inperiph.md
INPERIPH -- requirements
Module: inperiph

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter DW, default 8, width of the external input data.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 daddr  input  32  bus address from the biu; bits [3:2] select the register, all other bits are ignored.
REQ-006 drdata  output  32  read data; combinational from daddr and current state.
REQ-007 dwdata  input  32  write data from the CPU.
REQ-008 dwe  input  4  byte write enables; a register write occurs when dwe[0]=1.
REQ-009 in_data  input  DW  external byte stream data.
REQ-010 in_valid  input  1  external source presents in_data.
REQ-011 in_ready  output  1  peripheral accepts in_data this cycle.

Function
REQ-012 Register map by daddr[3:2]:
- 0 DATA (RO): FIFO head byte, zero-extended; non-destructive peek; 0 when the FIFO is empty.
- 1 STATUS (RO): [8:0] count; [9] empty; [10] full; [11] underflow (sticky); [31:16] total accepted bytes.
- 2 CTRL (WO): bit0 POP; bit1 FLUSH; bit2 CLR_UFL; reads return 0.
- 3 reserved: reads return 0; writes are ignored.
REQ-013 in_ready = !full, combinational; never depends on dwe or daddr.
REQ-014 Push:
- occurs when in_valid && in_ready at a clock edge;
- in_data is written at the tail in the same edge;
- the entry is visible on DATA/STATUS the next cycle (1-cycle latency).
REQ-015 A CTRL write with POP=1 removes the head entry at that edge.
REQ-016 POP while empty: no FIFO change; underflow sets to 1.
REQ-017 Simultaneous push and POP on a non-empty FIFO: count unchanged; head advances; the new byte is stored at the tail.
REQ-018 Push and POP on an empty FIFO in the same cycle: the pushed byte is stored, count becomes 1, and underflow sets.
REQ-019 FLUSH=1: read pointer, write pointer and count go to 0 at that edge. FLUSH has priority over POP and over a concurrent push; that pushed byte is discarded but still counted in total.
REQ-020 CLR_UFL=1 clears underflow. If CLR_UFL and an underflowing POP occur in the same write, set wins.
REQ-021 Total counter:
- 16-bit; +1 per completed handshake;
- wraps 0xFFFF -> 0x0000;
- cleared only by reset.
REQ-022 Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is a separate log2(DEPTH)+1-bit register, never exceeding DEPTH.
REQ-023 Writes with dwe[0]=0, or to any offset other than CTRL, have no effect.

Reset
REQ-024 While reset is high:
- pointers, count, underflow and total are 0;
- in_ready=1;
- DATA reads 0; STATUS reads 0x00000200.
REQ-025 Reset asserted mid-operation discards all FIFO contents immediately, without waiting for a clock edge.
REQ-026 No push or CTRL action takes effect on an edge where reset is high.

Structure
REQ-027 Package inperiph_pkg holds:
- register offsets (DATA=0x0, STATUS=0x4, CTRL=0x8);
- STATUS bit positions;
- CTRL bit positions.
REQ-028 One sub-module, inperiph_fifo, holds the storage, pointers and count, with push/pop/flush inputs and head/count/empty/full outputs. Register decode, the underflow flag and the total counter live in inperiph.

Verification
REQ-029 Reset, then read STATUS and DATA -> 0x00000200 and 0x0; in_ready=1.
REQ-030 Push 0x41, 0x42, 0x43 -> STATUS count=3, total=3; DATA=0x41. Write CTRL=0x1 -> DATA=0x42, count=2.
REQ-031 Push 16 bytes (DEPTH=16) -> full=1 and in_ready=0; a 17th in_valid is not accepted. POP once -> in_ready=1 and the 17th byte is accepted next edge.
REQ-032 POP on an empty FIFO -> underflow=1, count=0. CTRL=0x4 -> underflow=0. CTRL=0x5 on an empty FIFO -> underflow stays 1.
REQ-033 Hold in_valid for 8 cycles, writing CTRL=0x1 every cycle from cycle 2 onward -> count stays at 1 and DATA tracks the stream in order. Then FLUSH concurrent with a push -> count=0 and total incremented.
REQ-034 Assert reset asynchronously between edges with count=5 -> count reads 0 immediately; total = 0 after release.
